tile_match_controller: RTL and testbench
========================================

Name: tile_match_controller

Overview:
Game-side sequencer for the 16-entry tile colour RAM. It accepts player tile selections and reads the two chosen tiles through RAM ports A and B. It compares their colours and, on a match, writes CLEARED_COLOR back to both entries; on a mismatch it shows both tiles for a hold period and then hides them. It exports reveal/matched masks for the VGA renderer, plus score, move count and win status.

Parameters:
HIDE_CYCLES, 25000000, gameClk cycles a mismatched pair stays revealed (>=1)
CLEARED_COLOR, 8'h00, colour written to both entries of a matched pair
NUM_PAIRS, 8, pairs needed to win

Ports:
gameClk  in  1  game clock; all logic on posedge
reset  in  1  synchronous, active-high
select  in  1  one-cycle selection strobe
selIndex  in  4  tile index sampled with select
addrA  out  4  RAM port A address; registered, always equals firstIdx
writeA  out  8  RAM port A write data
weA  out  1  RAM port A write enable
readA  in  8  RAM port A registered read data (1-cycle latency)
addrB  out  4  RAM port B address; registered, always equals secondIdx
writeB  out  8  RAM port B write data
weB  out  1  RAM port B write enable
readB  in  8  RAM port B registered read data (1-cycle latency)
revealMask  out  16  tiles currently face-up but unmatched
matchedMask  out  16  tiles already matched
busy  out  1  high in READ, COMPARE, CLEAR, SHOW
matchPulse  out  1  one cycle, asserted in CLEAR
missPulse  out  1  one cycle, on the COMPARE->SHOW transition
pairsFound  out  4  matched pair count, 0..NUM_PAIRS
moves  out  8  completed pair attempts, saturates at 255
gameWon  out  1  high in DONE

Behaviour:
- Reset (sync, highest priority; applies in any state including mid-CLEAR or mid-SHOW):
  - State goes to IDLE.
  - All outputs and registers clear to 0, including firstIdx, secondIdx and the hold counter.
  - The reset edge deasserts weA/weB.
  - RAM contents are not restored.
- A selection is valid only when all of these hold:
  - select=1;
  - the state is IDLE or FIRST;
  - matchedMask[selIndex]=0;
  - in FIRST, selIndex != firstIdx.
  Invalid selections are ignored with no state change.
- IDLE: on a valid selection, firstIdx<=selIndex, revealMask[selIndex]<=1, go to FIRST.
- FIRST: on a valid selection, secondIdx<=selIndex, revealMask[selIndex]<=1, go to READ.
- READ (1 cycle): addrA/addrB are stable and the RAM samples them at the end-of-cycle edge. Go to COMPARE.
- COMPARE (1 cycle):
  - moves<=moves+1, saturating at 255.
  - If readA==readB: go to CLEAR.
  - Otherwise: missPulse=1 for the next cycle, hold counter<=HIDE_CYCLES-1, go to SHOW.
- CLEAR (1 cycle):
  - weA=weB=1, writeA=writeB=CLEARED_COLOR, matchPulse=1.
  - At the exit edge: matchedMask sets both bits, revealMask clears both bits, pairsFound+1.
  - Next state is DONE if the new pairsFound==NUM_PAIRS, otherwise IDLE.
- SHOW: counter decrements each cycle. When it reaches 0, revealMask clears both bits and the state goes to IDLE. Total time in SHOW is exactly HIDE_CYCLES cycles.
- DONE: gameWon=1 and all selects are ignored until reset.
- weA/weB are 0 in every state except CLEAR. writeA/writeB are 0 outside CLEAR.
- Latency: from the edge that samples the second select to the first CLEAR cycle is 2 cycles (READ, COMPARE).
- Simultaneous events: select during busy is dropped, not queued.

Test Plan:
1. Reset, then select 0, then select 14 (both 8'h3C in the power-on image) -> READ, COMPARE, then 1 CLEAR cycle with weA=weB=1, addrA=0, addrB=14, writeA=writeB=8'h00, matchPulse=1. Afterwards matchedMask=16'h4001, revealMask=0, pairsFound=1, moves=1.
2. Select 0, then 1 (8'h3C vs 8'hC8), with HIDE_CYCLES=4 -> missPulse for 1 cycle. revealMask=16'h0003 for exactly 4 cycles, then 0. weA and weB never assert. moves=1.
3. Select 5 twice; then, after matching 0/14, select 0; also strobe select in SHOW -> all ignored. State, masks and moves are unchanged, and busy holds.
4. Match all pairs (0/14, 1/8, 2/3, 4/9, 5/12, 6/10, 7/15, 11/13) -> pairsFound=8, gameWon=1, matchedMask=16'hFFFF. Further selects are ignored.
5. Assert reset during SHOW, and separately during CLEAR -> next cycle all outputs are 0, weA/weB are low, and the state is IDLE. A subsequent select 2 / select 3 completes normally as a match.
6. Force 256 mismatched attempts -> moves saturates at 255 and does not wrap.

Source files
------------

// File: rtl/tile_match_controller.sv
// Purpose: sequences a two-tile pick on the 16-entry colour RAM. It reads both tiles, then clears a matched
//          pair or shows a mismatched pair for HIDE_CYCLES.
// Latency: second-select edge -> READ -> COMPARE -> CLEAR/SHOW. The first CLEAR cycle comes 2 cycles after the second select.
// Backpressure: none. A select while busy (or in DONE) is dropped, not queued.
// Ports:
//   gameClk/reset        : clock, synchronous active-high reset
//   select/selIndex      : one-cycle tile pick strobe and index
//   addrA/writeA/weA/readA, addrB/writeB/weB/readB : dual-port colour RAM, 1-cycle registered read
//   revealMask/matchedMask : face-up-unmatched and matched tile masks for the renderer
//   busy/matchPulse/missPulse/pairsFound/moves/gameWon : game status
module tile_match_controller #(
   parameter int          HIDE_CYCLES   = 25000000,
   parameter logic [7:0]  CLEARED_COLOR = 8'h00,
   parameter int          NUM_PAIRS     = 8
) (
   input  logic        gameClk,
   input  logic        reset,
   input  logic        select,
   input  logic [3:0]  selIndex,
   output logic [3:0]  addrA,
   output logic [7:0]  writeA,
   output logic        weA,
   input  logic [7:0]  readA,
   output logic [3:0]  addrB,
   output logic [7:0]  writeB,
   output logic        weB,
   input  logic [7:0]  readB,
   output logic [15:0] revealMask,
   output logic [15:0] matchedMask,
   output logic        busy,
   output logic        matchPulse,
   output logic        missPulse,
   output logic [3:0]  pairsFound,
   output logic [7:0]  moves,
   output logic        gameWon
);

   localparam int         CW           = (HIDE_CYCLES > 1) ? $clog2(HIDE_CYCLES) : 1;
   localparam logic [3:0] PAIRS_TO_WIN = 4'(NUM_PAIRS);

   typedef enum logic [2:0] {
      IDLE, FIRST, READ, COMPARE, CLEAR, SHOW, DONE
   } state_t;

   state_t          state;
   logic [3:0]      firstIdx;
   logic [3:0]      secondIdx;
   logic [CW-1:0]   holdCnt;
   logic            validSel;
   logic [3:0]      pairsNext;

   // The RAM addresses are the index registers themselves, so they are stable from the select edge onward.
   assign addrA = firstIdx;
   assign addrB = secondIdx;

   assign validSel  = select && !matchedMask[selIndex] &&
                      ((state == IDLE) || ((state == FIRST) && (selIndex != firstIdx)));
   assign pairsNext = pairsFound + 4'd1;

   always_ff @(posedge gameClk) begin
      if (reset) begin
         state       <= IDLE;
         firstIdx    <= '0;
         secondIdx   <= '0;
         holdCnt     <= '0;
         revealMask  <= '0;
         matchedMask <= '0;
         busy        <= 1'b0;
         matchPulse  <= 1'b0;
         missPulse   <= 1'b0;
         weA         <= 1'b0;
         weB         <= 1'b0;
         writeA      <= '0;
         writeB      <= '0;
         pairsFound  <= '0;
         moves       <= '0;
         gameWon     <= 1'b0;
      end else begin
         // Pulses and write strobes last one cycle. They are re-raised only on entry to CLEAR or SHOW.
         matchPulse <= 1'b0;
         missPulse  <= 1'b0;
         weA        <= 1'b0;
         weB        <= 1'b0;
         writeA     <= '0;
         writeB     <= '0;

         case (state)
            IDLE: begin
               if (validSel) begin
                  firstIdx             <= selIndex;
                  revealMask[selIndex] <= 1'b1;
                  state                <= FIRST;
               end
            end
            FIRST: begin
               if (validSel) begin
                  secondIdx            <= selIndex;
                  revealMask[selIndex] <= 1'b1;
                  busy                 <= 1'b1;
                  state                <= READ;
               end
            end
            READ: begin
               // RAM samples addrA/addrB at the end of this cycle, and its data is valid in COMPARE.
               state <= COMPARE;
            end
            COMPARE: begin
               if (moves != 8'hFF) begin
                  moves <= moves + 8'd1;
               end
               if (readA == readB) begin
                  weA        <= 1'b1;
                  weB        <= 1'b1;
                  writeA     <= CLEARED_COLOR;
                  writeB     <= CLEARED_COLOR;
                  matchPulse <= 1'b1;
                  state      <= CLEAR;
               end else begin
                  missPulse <= 1'b1;
                  holdCnt   <= CW'(HIDE_CYCLES - 1);
                  state     <= SHOW;
               end
            end
            CLEAR: begin
               matchedMask[firstIdx]  <= 1'b1;
               matchedMask[secondIdx] <= 1'b1;
               revealMask[firstIdx]   <= 1'b0;
               revealMask[secondIdx]  <= 1'b0;
               pairsFound             <= pairsNext;
               busy                   <= 1'b0;
               if (pairsNext == PAIRS_TO_WIN) begin
                  gameWon <= 1'b1;
                  state   <= DONE;
               end else begin
                  state <= IDLE;
               end
            end
            SHOW: begin
               // The counter is loaded with HIDE_CYCLES-1 and exits on zero, so SHOW lasts HIDE_CYCLES cycles.
               if (holdCnt == '0) begin
                  revealMask[firstIdx]  <= 1'b0;
                  revealMask[secondIdx] <= 1'b0;
                  busy                  <= 1'b0;
                  state                 <= IDLE;
               end else begin
                  holdCnt <= holdCnt - 1'b1;
               end
            end
            DONE: begin
               gameWon <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_match_controller.sv
// Purpose: randomized self-checking bench for tile_match_controller with a behavioural RAM and a game-level model.
// Latency: expected pair results are queued at the second select and popped on matchPulse/missPulse.
// Backpressure: the stimulus waits for busy to drop before issuing the next pick, with a bounded wait.
module tb_tile_match_controller;

   localparam int         HIDE   = 4;
   localparam logic [7:0] CLR    = 8'h00;
   localparam int         NPAIRS = 8;

   logic        gameClk = 1'b0;
   logic        reset;
   logic        select;
   logic [3:0]  selIndex;
   logic [3:0]  addrA, addrB;
   logic [7:0]  writeA, writeB, readA, readB;
   logic        weA, weB;
   logic [15:0] revealMask, matchedMask;
   logic        busy, matchPulse, missPulse, gameWon;
   logic [3:0]  pairsFound;
   logic [7:0]  moves;

   int errors = 0;
   int checks = 0;

   tile_match_controller #(.HIDE_CYCLES(HIDE), .CLEARED_COLOR(CLR), .NUM_PAIRS(NPAIRS)) dut (
      .gameClk(gameClk), .reset(reset), .select(select), .selIndex(selIndex),
      .addrA(addrA), .writeA(writeA), .weA(weA), .readA(readA),
      .addrB(addrB), .writeB(writeB), .weB(weB), .readB(readB),
      .revealMask(revealMask), .matchedMask(matchedMask), .busy(busy),
      .matchPulse(matchPulse), .missPulse(missPulse), .pairsFound(pairsFound),
      .moves(moves), .gameWon(gameWon)
   );

   always #5 gameClk = ~gameClk;

   // Power-on colour image: pairs share a colour.
   function automatic logic [7:0] imageColour(input int i);
      case (i)
         0, 14:  return 8'h3C;
         1, 8:   return 8'hC8;
         2, 3:   return 8'h11;
         4, 9:   return 8'h22;
         5, 12:  return 8'h33;
         6, 10:  return 8'h44;
         7, 15:  return 8'h55;
         default: return 8'h66;
      endcase
   endfunction

   // Behavioural dual-port RAM with registered reads.
   logic [7:0] ram [16];
   logic       loadRam;
   always @(posedge gameClk) begin
      if (loadRam) begin
         for (int i = 0; i < 16; i++) ram[i] <= imageColour(i);
      end else begin
         if (weA) ram[addrA] <= writeA;
         if (weB) ram[addrB] <= writeB;
      end
      readA <= ram[addrA];
      readB <= ram[addrB];
   end

   // Game-level reference model.
   logic [7:0]  mColour [16];
   logic [15:0] mMatched;
   int          mPairs, mMoves, mFirst;
   bit          mDone, mHaveFirst;

   typedef struct {
      bit isMatch;
      int a;
      int b;
      int movesExp;
      bit abort;
   } exp_t;
   exp_t sb[$];

   int pA[8] = '{0, 1, 2, 4, 5, 6, 7, 11};
   int pB[8] = '{14, 8, 3, 9, 12, 10, 15, 13};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mMatched   = '0;
      mPairs     = 0;
      mMoves     = 0;
      mDone      = 0;
      mHaveFirst = 0;
      mFirst     = 0;
   endtask

   task automatic pick(input int idx, input bit abort);
      bit   valid;
      exp_t e;
      valid = !mDone && !mMatched[idx] && !(mHaveFirst && idx == mFirst);
      @(negedge gameClk);
      select   = 1'b1;
      selIndex = 4'(idx);
      @(negedge gameClk);
      select = 1'b0;
      if (valid) begin
         if (!mHaveFirst) begin
            mHaveFirst = 1;
            mFirst     = idx;
         end else begin
            mHaveFirst = 0;
            if (mMoves < 255) mMoves++;
            e.isMatch  = (mColour[mFirst] == mColour[idx]);
            e.a        = mFirst;
            e.b        = idx;
            e.movesExp = mMoves;
            e.abort    = abort;
            sb.push_back(e);
            if (e.isMatch) begin
               mMatched[mFirst] = 1'b1;
               mMatched[idx]    = 1'b1;
               mColour[mFirst]  = CLR;
               mColour[idx]     = CLR;
               mPairs++;
               if (mPairs == NPAIRS) mDone = 1;
            end
         end
      end
   endtask

   task automatic waitIdle(input string tag);
      int n;
      for (n = 0; n < 100; n++) begin
         if (!busy) break;
         @(negedge gameClk);
      end
      if (n == 100) begin
         checks++;
         errors++;
         $display("FAIL %s idle timeout: busy still %0b after 100 cycles, required 0", tag, busy);
      end
   endtask

   task automatic attempt(input int a, input int b);
      pick(a, 0);
      pick(b, 0);
      waitIdle("attempt");
   endtask

   task automatic checkState(input string tag);
      logic [15:0] rv;
      rv = mHaveFirst ? (16'd1 << mFirst) : 16'd0;
      chk({tag, " revealMask"},  32'(revealMask),  32'(rv));
      chk({tag, " matchedMask"}, 32'(matchedMask), 32'(mMatched));
      chk({tag, " pairsFound"},  32'(pairsFound),  32'(mPairs));
      chk({tag, " moves"},       32'(moves),       32'(mMoves));
      chk({tag, " gameWon"},     32'(gameWon),     32'(mDone));
      chk({tag, " busy"},        32'(busy),        32'd0);
   endtask

   task automatic checkZero(input string tag);
      chk({tag, " revealMask"},  32'(revealMask),  32'd0);
      chk({tag, " matchedMask"}, 32'(matchedMask), 32'd0);
      chk({tag, " pairsFound"},  32'(pairsFound),  32'd0);
      chk({tag, " moves"},       32'(moves),       32'd0);
      chk({tag, " gameWon"},     32'(gameWon),     32'd0);
      chk({tag, " busy"},        32'(busy),        32'd0);
      chk({tag, " pulses"},      32'({matchPulse, missPulse}), 32'd0);
      chk({tag, " we"},          32'({weA, weB}),  32'd0);
      chk({tag, " writeData"},   32'({writeA, writeB}), 32'd0);
      chk({tag, " addr"},        32'({addrA, addrB}),   32'd0);
   endtask

   // Monitor: pops one expected result per pulse. It also checks that writes appear only alongside matchPulse.
   initial begin
      exp_t        e;
      int          n;
      logic [15:0] rm;
      forever begin
         @(negedge gameClk);
         if (!matchPulse) begin
            chk("write outside CLEAR", 32'({weA, weB, writeA, writeB}), 32'd0);
         end
         if (matchPulse || missPulse) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected pulse: match=%0b miss=%0b with empty scoreboard", matchPulse, missPulse);
            end else begin
               e  = sb.pop_front();
               rm = (16'd1 << e.a) | (16'd1 << e.b);
               chk("matchPulse", 32'(matchPulse), 32'(e.isMatch));
               chk("missPulse",  32'(missPulse),  32'(!e.isMatch));
               chk("addrA", 32'(addrA), 32'(e.a));
               chk("addrB", 32'(addrB), 32'(e.b));
               chk("moves at result", 32'(moves), 32'(e.movesExp));
               chk("weA/weB", 32'({weA, weB}), e.isMatch ? 32'd3 : 32'd0);
               if (e.isMatch) begin
                  chk("clear writeData", 32'({writeA, writeB}), 32'({CLR, CLR}));
               end
               if (!e.isMatch && !e.abort) begin
                  n = 1;
                  chk("show revealMask", 32'(revealMask), 32'(rm));
                  while (busy && n < HIDE + 10) begin
                     @(negedge gameClk);
                     if (busy) begin
                        n++;
                        chk("show revealMask", 32'(revealMask), 32'(rm));
                        chk("show we", 32'({weA, weB}), 32'd0);
                     end
                  end
                  chk("show length", 32'(n), 32'(HIDE));
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, b, tmp, guard;
      int order[8];

      reset    = 1'b1;
      select   = 1'b0;
      selIndex = '0;
      loadRam  = 1'b1;
      for (int i = 0; i < 16; i++) mColour[i] = imageColour(i);
      modelReset();
      repeat (3) @(negedge gameClk);
      loadRam = 1'b0;
      reset   = 1'b0;
      checkZero("reset");

      // Mismatch 0/1, then match 0/14.
      attempt(0, 1);
      checkState("miss 0/1");
      attempt(0, 14);
      checkState("match 0/14");

      // Ignored selections: repeat of first, matched tile, and a strobe during SHOW.
      pick(5, 0);
      pick(5, 0);
      pick(0, 0);
      pick(1, 0);
      @(negedge gameClk);
      @(negedge gameClk);
      select   = 1'b1;
      selIndex = 4'd7;
      @(negedge gameClk);
      select = 1'b0;
      chk("busy holds in SHOW", 32'(busy), 32'd1);
      chk("reveal in SHOW", 32'(revealMask), 32'h0022);
      waitIdle("ignored");
      checkState("ignored");

      // Reset during SHOW.
      pick(1, 0);
      pick(2, 1);
      repeat (3) @(negedge gameClk);
      reset = 1'b1;
      @(negedge gameClk);
      reset = 1'b0;
      modelReset();
      checkZero("reset in SHOW");

      // Reset during CLEAR. The RAM write still lands on the reset edge.
      pick(2, 0);
      pick(3, 1);
      repeat (2) @(negedge gameClk);
      reset = 1'b1;
      @(negedge gameClk);
      reset = 1'b0;
      modelReset();
      checkZero("reset in CLEAR");
      attempt(2, 3);
      checkState("match after reset");

      // Random mismatches until moves saturates.
      for (int k = 0; k < 260; k++) begin
         guard = 0;
         do begin
            a = int'($urandom_range(15));
            b = int'($urandom_range(15));
            guard++;
         end while ((a == b || mMatched[a] || mMatched[b] || mColour[a] == mColour[b]) && guard < 1000);
         attempt(a, b);
      end
      checkState("saturated");
      chk("moves saturated", 32'(moves), 32'd255);

      // Full game in random pair order, with ignored picks interleaved.
      @(negedge gameClk);
      reset = 1'b1;
      @(negedge gameClk);
      reset = 1'b0;
      modelReset();
      checkZero("reset before game");
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
         tmp = int'($urandom_range(i));
         a = order[i];
         order[i] = order[tmp];
         order[tmp] = a;
      end
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(1) == 1) begin
            a = pA[order[i]];
            b = pB[order[i]];
         end else begin
            a = pB[order[i]];
            b = pA[order[i]];
         end
         pick(a, 0);
         pick(a, 0);
         if (mMatched != 16'd0) begin
            guard = 0;
            do begin
               tmp = int'($urandom_range(15));
               guard++;
            end while (!mMatched[tmp] && guard < 200);
            pick(tmp, 0);
         end
         pick(b, 0);
         waitIdle("game");
         checkState("game pair");
      end
      chk("final matchedMask", 32'(matchedMask), 32'hFFFF);
      chk("final pairsFound", 32'(pairsFound), 32'd8);
      chk("final gameWon", 32'(gameWon), 32'd1);

      // Picks in DONE are ignored.
      for (int k = 0; k < 4; k++) pick(int'($urandom_range(15)), 0);
      repeat (3) @(negedge gameClk);
      checkState("done ignored");

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
